// File: rtl/decoder_frame_counter.sv
// Codeword bit-position tracker with completed-frame counter.
// Walks bit_idx through each codeword and pulses write when the last bit is accepted.
//
// state | meaning
// IDLE  | no frame in progress, waiting for start
// RUN   | accepting codeword bits, bit_idx is the next position
module decoder_frame_counter #(
  parameter int MAX_LEN = 15,
  parameter int CNT_W   = 4,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               start,
  input  logic               cont,
  input  logic               abort,
  input  logic [CNT_W-1:0]   code_len,
  output logic [CNT_W-1:0]   bit_idx,
  output logic               first,
  output logic               last,
  output logic               write,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy,
  output logic               len_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

  state_t             state, state_n;
  logic [CNT_W-1:0]   len_q, len_n;
  logic               cont_q, cont_n;
  logic [CNT_W-1:0]   idx_n;
  logic [FRAME_W-1:0] cnt_n;
  logic               write_n, len_err_n;
  logic               len_bad;
  logic [CNT_W-1:0]   len_legal;
  logic               at_end;

  // Out-of-range lengths fall back to the longest codeword.
  assign len_bad   = (code_len < CNT_W'(2)) || (code_len > MAX_L);
  assign len_legal = len_bad ? MAX_L : code_len;
  assign at_end    = (bit_idx == len_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      len_q     <= MAX_L;
      cont_q    <= 1'b0;
      frame_cnt <= '0;
      write     <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_idx   <= idx_n;
      len_q     <= len_n;
      cont_q    <= cont_n;
      frame_cnt <= cnt_n;
      write     <= write_n;
      len_err   <= len_err_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = bit_idx;
    len_n     = len_q;
    cont_n    = cont_q;
    cnt_n     = frame_cnt;
    write_n   = 1'b0;
    len_err_n = 1'b0;
    if (abort) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n   = RUN;
            idx_n     = '0;
            len_n     = len_legal;
            cont_n    = cont;
            len_err_n = len_bad;
          end
        end
        RUN: begin
          if (en) begin
            if (at_end) begin
              idx_n   = '0;
              write_n = 1'b1;
              cnt_n   = frame_cnt + FRAME_W'(1);
              // Continuous mode chains straight into the next codeword.
              if (cont_q) begin
                len_n     = len_legal;
                len_err_n = len_bad;
              end else begin
                state_n = IDLE;
              end
            end else begin
              idx_n = bit_idx + CNT_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy  = (state == RUN);
  assign first = busy && (bit_idx == '0);
  assign last  = busy && at_end;

endmodule

// File: doc/decoder_frame_counter.md
DECODER_FRAME_COUNTER -- requirements
Module: decoder_frame_counter

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 15, maximum codeword length in bits (legal 2..2^CNT_W-1).
REQ-002 SHALL provide parameter CNT_W, default 4, width of bit index and length fields.
REQ-003 SHALL provide parameter FRAME_W, default 8, width of completed-frame counter.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 en  input  1  one codeword bit accepted this cycle.
REQ-007 start  input  1  begin frame from IDLE.
REQ-008 cont  input  1  continuous mode, sampled with start.
REQ-009 abort  input  1  synchronous frame abort.
REQ-010 code_len  input  CNT_W  codeword length L, sampled at each frame begin.
REQ-011 bit_idx  output  CNT_W  index of next bit to be accepted.
REQ-012 first  output  1  RUN and bit_idx==0 (combinational from registers).
REQ-013 last  output  1  RUN and bit_idx==L-1 (combinational from registers).
REQ-014 write  output  1  registered one-cycle pulse: codeword complete.
REQ-015 frame_cnt  output  FRAME_W  completed codewords since reset.
REQ-016 busy  output  1  state != IDLE.
REQ-017 len_err  output  1  registered one-cycle pulse: illegal code_len sampled.

Function
REQ-018 States SHALL be IDLE and RUN only.
REQ-019 IDLE with start=1 SHALL go to RUN, latch L and cont, set bit_idx=0; en in that same cycle SHALL NOT be counted.
REQ-020 Sampled code_len <2 or >MAX_LEN SHALL be replaced by MAX_LEN and pulse len_err next cycle.
REQ-021 RUN, en=1, bit_idx<L-1: bit_idx SHALL increment by 1.
REQ-022 RUN, en=1, bit_idx==L-1: bit_idx SHALL go to 0, write SHALL be 1 next cycle, frame_cnt SHALL increment.
REQ-023 At completion with latched cont=1: stay RUN, re-sample code_len as new L (REQ-020 applies); cont=0: go IDLE.
REQ-024 RUN with en=0 SHALL hold bit_idx and all state; write SHALL be 0.
REQ-025 write SHALL be 0 in every cycle not directly following a completing en cycle (never held high).
REQ-026 start while in RUN SHALL be ignored.
REQ-027 abort=1 SHALL force IDLE, bit_idx=0, no write, frame_cnt unchanged; abort on a completing cycle suppresses completion.
REQ-028 Priority SHALL be reset > abort > start/en.
REQ-029 frame_cnt SHALL wrap 2^FRAME_W-1 -> 0 without flag.
REQ-030 first/last SHALL be 0 in IDLE; both 1 impossible since L>=2.

Reset
REQ-031 reset=0 at rising edge SHALL set IDLE, bit_idx=0, L=MAX_LEN, cont=0, frame_cnt=0, write=0, len_err=0, busy=0, regardless of other inputs.
REQ-032 Reset mid-frame SHALL discard partial frame with no write pulse.

Verification
REQ-033 start, code_len=11, cont=0, then 11 en cycles -> bit_idx 0..10, last at idx 10, write=1 one cycle after 11th en, frame_cnt=1, busy=0.
REQ-034 cont=1, code_len=7, 21 contiguous en -> write pulses after en 7, 14, 21, frame_cnt=3, busy stays 1, bit_idx=0.
REQ-035 code_len=1 or 0 with start -> len_err pulse, L=15; 15 en -> one write.
REQ-036 L=11, en gaps after bits 3 and 9 -> bit_idx holds, write only after 11th accepted en, write never 2 cycles.
REQ-037 abort at bit_idx=5, and abort with completing en -> IDLE, no write, frame_cnt unchanged; reset=0 at bit_idx=6 -> all outputs reset values.
REQ-038 FRAME_W=2, 5 frames of L=2 -> frame_cnt 1,2,3,0,1.
